lsu_mem_port: RTL and testbench

- Memory-access unit that services the data-RAM control signals emitted by the instruction decoder: data_ram_en, data_ram_wen, wmask and l_choose.
- Turns one load or store per instruction into a valid/ready request on the data-memory bus, waits for the response, and extends load data.
- Returns mem_finish, which gates register-file and CSR writes.
- Sits between decode/ALU (address) and the data memory or AXI bridge.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_mem_port_if.sv | 34 +++
 rtl/lsu_load_ext.sv | 41 ++++
 rtl/lsu_mem_port.sv | 165 ++++++++++++++++
 tb/tb_lsu_mem_port.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the LSU memory port. Holds the FSM
//               state type, the l_choose bit positions and the canonical
//               store byte masks.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } lsu_state_e;

  // Bit positions inside the one-hot l_choose vector
  localparam int LD  = 0;
  localparam int LW  = 1;
  localparam int LWU = 2;
  localparam int LH  = 3;
  localparam int LHU = 4;
  localparam int LB  = 5;
  localparam int LBU = 6;

  // LSB-aligned store byte masks
  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/lsu_mem_port_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_port_if
// Description : Data-memory bus between the LSU and memory / AXI bridge.
//               Request channel: valid/ready with wen, addr, wdata, wstrb.
//               Response channel: rsp_valid with aligned 8-byte read data.
//   master : the LSU (drives the request, consumes the response)
//   slave  : the memory side
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_port_if #(
  parameter int XLEN = 64,
  parameter int AW   = 32
);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_wen;
  logic [AW-1:0]   mem_req_addr;
  logic [XLEN-1:0] mem_req_wdata;
  logic [7:0]      mem_req_wstrb;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/lsu_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_ext
// Description : Combinational load lane select and sign/zero extension.
//   rsp_data  in  XLEN  aligned 8-byte read data
//   offset    in  3     byte offset of the access inside the 8-byte word
//   l_choose  in  7     one-hot load type
//   load_data out XLEN  extended result (0 for zero / non-one-hot l_choose)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rsp_data,
  input  logic [2:0]      offset,
  input  logic [6:0]      l_choose,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] w_lane;

  always_comb begin
    // Move the addressed byte down to bit 0
    w_lane    = rsp_data >> {offset, 3'b000};
    load_data = '0;
    case (l_choose)
      7'(1 << LD):  load_data = w_lane;
      7'(1 << LW):  load_data = {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
      7'(1 << LWU): load_data = {{(XLEN-32){1'b0}},       w_lane[31:0]};
      7'(1 << LH):  load_data = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      7'(1 << LHU): load_data = {{(XLEN-16){1'b0}},       w_lane[15:0]};
      7'(1 << LB):  load_data = {{(XLEN-8){w_lane[7]}},   w_lane[7:0]};
      7'(1 << LBU): load_data = {{(XLEN-8){1'b0}},        w_lane[7:0]};
      default:      load_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_port
// Description : Executes at most one load or store per instruction on the
//               data-memory bus and reports completion via mem_finish.
//   clk, rst             clock, synchronous active-high reset
//   inst_update          new-instruction pulse (re-arms the unit)
//   data_ram_en/_wen     load / store request from decode
//   wmask, l_choose      store byte mask / one-hot load type
//   addr, wdata          effective address, LSB-aligned store data
//   bus                  data-memory bus (master side)
//   mem_finish           memory phase complete (gates RF/CSR writes)
//   load_data            extended load result
//   mem_err              one-cycle pulse on misaligned or en&wen access
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_update,
  input  logic              data_ram_en,
  input  logic              data_ram_wen,
  input  logic [7:0]        wmask,
  input  logic [6:0]        l_choose,
  input  logic [AW-1:0]     addr,
  input  logic [XLEN-1:0]   wdata,
  lsu_mem_port_if.master    bus,
  output logic              mem_finish,
  output logic [XLEN-1:0]   load_data,
  output logic              mem_err
);

  lsu_state_e      r_state;
  logic            r_served;
  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [7:0]      r_wmask;
  logic [6:0]      r_l_choose;
  logic            r_is_load;
  logic            r_is_store;
  logic            r_req_valid;
  logic            r_req_wen;
  logic [AW-1:0]   r_req_addr;
  logic [XLEN-1:0] r_req_wdata;
  logic [7:0]      r_req_wstrb;
  logic [XLEN-1:0] r_load_data;
  logic            r_err;

  logic            w_misaligned;
  logic            w_conflict;
  logic [XLEN-1:0] w_ext;

  // Access size comes from l_choose for loads and from wmask for stores
  always_comb begin
    w_misaligned = 1'b0;
    if (r_is_load) begin
      if (r_l_choose[LD])                      w_misaligned = |r_addr[2:0];
      else if (r_l_choose[LW] | r_l_choose[LWU]) w_misaligned = |r_addr[1:0];
      else if (r_l_choose[LH] | r_l_choose[LHU]) w_misaligned = r_addr[0];
    end else begin
      case (r_wmask)
        MASK_D:  w_misaligned = |r_addr[2:0];
        MASK_W:  w_misaligned = |r_addr[1:0];
        MASK_H:  w_misaligned = r_addr[0];
        default: w_misaligned = 1'b0;
      endcase
    end
  end

  assign w_conflict = r_is_load & r_is_store;

  lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
    .rsp_data  (bus.mem_rsp_data),
    .offset    (r_addr[2:0]),
    .l_choose  (r_l_choose),
    .load_data (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_served    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_l_choose  <= '0;
      r_is_load   <= 1'b0;
      r_is_store  <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_wen   <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_wstrb <= '0;
      r_load_data <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (inst_update) r_served <= 1'b0;
      case (r_state)
        IDLE: begin
          if ((data_ram_en | data_ram_wen) & ~r_served) begin
            r_addr     <= addr;
            r_wdata    <= wdata;
            r_wmask    <= wmask;
            r_l_choose <= l_choose;
            r_is_load  <= data_ram_en;
            r_is_store <= data_ram_wen;
            r_state    <= CHECK;
          end
        end
        CHECK: begin
          if (w_misaligned | w_conflict) begin
            r_err       <= 1'b1;
            r_load_data <= '0;
            r_state     <= DONE;
          end else begin
            // Request fields are registered here and held until handshake
            r_req_valid <= 1'b1;
            r_req_wen   <= r_is_store;
            r_req_addr  <= {r_addr[AW-1:3], 3'b000};
            r_req_wdata <= r_wdata << {r_addr[2:0], 3'b000};
            r_req_wstrb <= r_wmask << r_addr[2:0];
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            if (r_is_load) r_load_data <= w_ext;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
          // A coincident inst_update re-arms immediately
          if (!inst_update) r_served <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req_valid = r_req_valid;
  assign bus.mem_req_wen   = r_req_wen;
  assign bus.mem_req_addr  = r_req_addr;
  assign bus.mem_req_wdata = r_req_wdata;
  assign bus.mem_req_wstrb = r_req_wstrb;

  // Non-memory instructions complete in the cycle they are presented
  assign mem_finish = ~(data_ram_en | data_ram_wen) | (r_state == DONE);
  assign load_data  = r_load_data;
  assign mem_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_port
// Description : Self-checking bench for lsu_mem_port with a behavioural
//               reference model of alignment, lane selection and extension.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_port;

  localparam int XLEN = 64;
  localparam int AW   = 32;

  logic            clk = 1'b0;
  logic            rst, inst_update, data_ram_en, data_ram_wen;
  logic [7:0]      wmask;
  logic [6:0]      l_choose;
  logic [AW-1:0]   addr;
  logic [XLEN-1:0] wdata;
  logic            mem_finish, mem_err;
  logic [XLEN-1:0] load_data;

  int checks   = 0;
  int failures = 0;

  lsu_mem_port_if #(.XLEN(XLEN), .AW(AW)) bus ();

  lsu_mem_port #(.XLEN(XLEN), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_update  (inst_update),
    .data_ram_en  (data_ram_en),
    .data_ram_wen (data_ram_wen),
    .wmask        (wmask),
    .l_choose     (l_choose),
    .addr         (addr),
    .wdata        (wdata),
    .bus          (bus),
    .mem_finish   (mem_finish),
    .load_data    (load_data),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int load_bytes(input logic [6:0] lch);
    case (lch)
      7'h01:        return 8;
      7'h02, 7'h04: return 4;
      7'h08, 7'h10: return 2;
      7'h20, 7'h40: return 1;
      default:      return 0;
    endcase
  endfunction

  function automatic bit load_signed(input logic [6:0] lch);
    return (lch == 7'h02) || (lch == 7'h08) || (lch == 7'h20);
  endfunction

  function automatic int store_bytes(input logic [7:0] wm);
    case (wm)
      8'h03:   return 2;
      8'h0F:   return 4;
      8'hFF:   return 8;
      default: return 1;
    endcase
  endfunction

  function automatic bit model_err(input bit en, input bit wen, input logic [31:0] a,
                                   input logic [6:0] lch, input logic [7:0] wm);
    int n;
    if (en && wen) return 1'b1;
    n = en ? load_bytes(lch) : store_bytes(wm);
    if (n == 0) n = 1;
    return (int'(a[2:0]) % n) != 0;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rsp, input logic [31:0] a,
                                             input logic [6:0] lch);
    int n;
    logic [63:0] v, m;
    n = load_bytes(lch);
    if (n == 0) return 64'd0;
    v = rsp >> (8 * int'(a[2:0]));
    if (n < 8) begin
      m = (64'd1 << (8 * n)) - 64'd1;
      v = v & m;
      if (load_signed(lch) && v[8*n-1]) v = v | ~m;
    end
    return v;
  endfunction

  logic [63:0] model_ld;   // value load_data is expected to hold

  // ---------------- observations from one op ----------------
  int          obs_fin_k, obs_fin_cnt, obs_req_cnt, obs_err_cnt, obs_valid_wait;
  bit          obs_fin0, obs_stable, obs_err_at_fin;
  logic [63:0] obs_load, obs_wdata;
  logic [31:0] obs_addr;
  logic [7:0]  obs_wstrb;
  logic        obs_wen;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; inst_update = 1'b0; data_ram_en = 1'b0; data_ram_wen = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ld = 64'd0;
  endtask

  // Presents one op (after re-arming with inst_update), acts as memory, and
  // records what the DUT did until a few cycles past mem_finish.
  task automatic run_op(input bit en, input bit wen, input logic [31:0] a,
                        input logic [63:0] wd, input logic [7:0] wm, input logic [6:0] lch,
                        input int rwait, input int swait, input logic [63:0] rdata,
                        input bit iu_at_done);
    int  vcnt, wcnt;
    bit  hs, rsp_done, prev_v;
    @(negedge clk);
    inst_update = 1'b1; data_ram_en = 1'b0; data_ram_wen = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    inst_update = 1'b0; data_ram_en = en; data_ram_wen = wen;
    addr = a; wdata = wd; wmask = wm; l_choose = lch;
    #1 obs_fin0 = mem_finish;
    obs_fin_k = -1; obs_fin_cnt = 0; obs_req_cnt = 0; obs_err_cnt = 0;
    obs_valid_wait = 0; obs_stable = 1'b1; obs_err_at_fin = 1'b0; obs_load = '0;
    obs_addr = '0; obs_wdata = '0; obs_wstrb = '0; obs_wen = 1'b0;
    vcnt = 0; wcnt = 0; hs = 1'b0; rsp_done = 1'b0; prev_v = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      inst_update = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
      if (hs && !rsp_done) begin
        wcnt++;
        if (wcnt > swait) begin
          bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = rdata; rsp_done = 1'b1;
        end
      end
      if (bus.mem_req_valid) begin
        if (!prev_v) begin
          obs_req_cnt++;
          if (obs_req_cnt == 1) begin
            obs_addr = bus.mem_req_addr; obs_wdata = bus.mem_req_wdata;
            obs_wstrb = bus.mem_req_wstrb; obs_wen = bus.mem_req_wen;
          end
        end else if (obs_req_cnt == 1 &&
                     (obs_addr != bus.mem_req_addr || obs_wdata != bus.mem_req_wdata ||
                      obs_wstrb != bus.mem_req_wstrb || obs_wen != bus.mem_req_wen))
          obs_stable = 1'b0;
        if (obs_req_cnt == 1 && !hs) begin
          vcnt++;
          if (vcnt > rwait) begin
            bus.mem_req_ready = 1'b1; hs = 1'b1;
          end else obs_valid_wait++;
        end
      end
      prev_v = bus.mem_req_valid;
      if (mem_err) obs_err_cnt++;
      if (mem_finish) begin
        obs_fin_cnt++;
        if (obs_fin_k < 0) begin
          obs_fin_k = k; obs_load = load_data; obs_err_at_fin = mem_err;
          if (iu_at_done) inst_update = 1'b1;
        end
      end
      if (obs_fin_k >= 0 && k >= obs_fin_k + 4) break;
    end
    @(negedge clk);
    data_ram_en = 1'b0; data_ram_wen = 1'b0; inst_update = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.mem_req_valid); end
    checks++; if (bus.mem_req_addr !== 32'd0 || bus.mem_req_wstrb !== 8'd0 || bus.mem_req_wen !== 1'b0 || bus.mem_req_wdata !== 64'd0) begin
      failures++; $display("FAIL reset_req_fields got=%h/%h/%b/%h exp=0", bus.mem_req_addr, bus.mem_req_wstrb, bus.mem_req_wen, bus.mem_req_wdata); end
    checks++; if (load_data !== 64'd0) begin failures++; $display("FAIL reset_load got=%h exp=0", load_data); end
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", mem_err); end
  endtask

  task automatic test_non_mem();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      data_ram_en = 1'b0; data_ram_wen = 1'b0; inst_update = 1'($urandom_range(0, 1));
      addr = $urandom; wdata = {$urandom, $urandom}; l_choose = 7'($urandom); wmask = 8'($urandom);
      #1;
      checks++; if (mem_finish !== 1'b1) begin failures++; $display("FAIL nonmem_finish cyc=%0d got=%b exp=1", i, mem_finish); end
      checks++; if (bus.mem_req_valid !== 1'b0) begin failures++; $display("FAIL nonmem_valid cyc=%0d got=%b exp=0", i, bus.mem_req_valid); end
    end
    inst_update = 1'b0;
  endtask

  task automatic test_lb();
    logic [63:0] exp;
    run_op(1'b1, 1'b0, 32'h8000_0003, 64'd0, 8'h01, 7'h20, 0, 0, 64'h0000_0000_8000_0000, 1'b0);
    exp = model_load(64'h0000_0000_8000_0000, 32'h8000_0003, 7'h20);
    model_ld = exp;
    checks++; if (obs_addr !== 32'h8000_0000) begin failures++; $display("FAIL lb_addr got=%h exp=80000000", obs_addr); end
    checks++; if (obs_load !== 64'hFFFF_FFFF_FFFF_FF80 || obs_load !== exp) begin failures++; $display("FAIL lb_load got=%h exp=ffffffffffffff80", obs_load); end
    checks++; if (obs_fin_k != 4) begin failures++; $display("FAIL lb_latency got=%0d exp=4", obs_fin_k); end
    checks++; if (obs_fin_cnt != 1 || obs_fin0 !== 1'b0) begin failures++; $display("FAIL lb_finish_pulses got=%0d/%b exp=1/0", obs_fin_cnt, obs_fin0); end
    checks++; if (obs_wen !== 1'b0 || obs_err_cnt != 0) begin failures++; $display("FAIL lb_wen_err got=%b/%0d exp=0/0", obs_wen, obs_err_cnt); end
  endtask

  task automatic test_sh();
    run_op(1'b0, 1'b1, 32'h8000_0006, 64'h1234, 8'h03, 7'h00, 3, 0, {$urandom, $urandom}, 1'b0);
    checks++; if (obs_wstrb !== 8'hC0) begin failures++; $display("FAIL sh_wstrb got=%h exp=c0", obs_wstrb); end
    checks++; if (obs_wdata !== 64'h1234_0000_0000_0000) begin failures++; $display("FAIL sh_wdata got=%h exp=1234000000000000", obs_wdata); end
    checks++; if (obs_wen !== 1'b1) begin failures++; $display("FAIL sh_wen got=%b exp=1", obs_wen); end
    checks++; if (obs_valid_wait != 3 || !obs_stable) begin failures++; $display("FAIL sh_hold got=%0d/%b exp=3/1", obs_valid_wait, obs_stable); end
    checks++; if (obs_fin_k != 7) begin failures++; $display("FAIL sh_latency got=%0d exp=7", obs_fin_k); end
    checks++; if (obs_load !== model_ld) begin failures++; $display("FAIL sh_load_hold got=%h exp=%h", obs_load, model_ld); end
  endtask

  task automatic test_misaligned();
    run_op(1'b1, 1'b0, 32'h8000_0002, 64'd0, 8'h0F, 7'h02, 0, 0, {$urandom, $urandom}, 1'b0);
    model_ld = 64'd0;
    checks++; if (obs_req_cnt != 0) begin failures++; $display("FAIL mis_no_req got=%0d exp=0", obs_req_cnt); end
    checks++; if (obs_err_cnt != 1 || obs_err_at_fin !== 1'b1) begin failures++; $display("FAIL mis_err got=%0d/%b exp=1/1", obs_err_cnt, obs_err_at_fin); end
    checks++; if (obs_fin_cnt != 1 || obs_fin_k != 2) begin failures++; $display("FAIL mis_finish got=%0d@%0d exp=1@2", obs_fin_cnt, obs_fin_k); end
    checks++; if (obs_load !== 64'd0) begin failures++; $display("FAIL mis_load got=%h exp=0", obs_load); end
  endtask

  task automatic test_served();
    // held op: run_op keeps the op asserted for 4 cycles after finish
    run_op(1'b1, 1'b0, 32'h8000_0000, 64'd0, 8'hFF, 7'h01, 1, 1, 64'h1111_2222_3333_4444, 1'b0);
    checks++; if (obs_req_cnt != 1 || obs_fin_cnt != 1) begin failures++; $display("FAIL served_once got=%0d/%0d exp=1/1", obs_req_cnt, obs_fin_cnt); end
    run_op(1'b1, 1'b0, 32'h8000_0008, 64'd0, 8'hFF, 7'h01, 0, 2, 64'hDEAD_BEEF_0123_4567, 1'b0);
    model_ld = 64'hDEAD_BEEF_0123_4567;
    checks++; if (obs_req_cnt != 1 || obs_addr !== 32'h8000_0008) begin failures++; $display("FAIL served_new_req got=%0d@%h exp=1@80000008", obs_req_cnt, obs_addr); end
    checks++; if (obs_load !== model_ld || obs_fin_k != 6) begin failures++; $display("FAIL served_new_load got=%h@%0d exp=%h@6", obs_load, obs_fin_k, model_ld); end
  endtask

  task automatic test_update_at_done();
    run_op(1'b0, 1'b1, 32'h8000_0020, 64'h55, 8'h01, 7'h00, 0, 0, 64'd0, 1'b1);
    checks++; if (obs_req_cnt != 2) begin failures++; $display("FAIL iu_at_done_rearm got=%0d exp=2", obs_req_cnt); end
    do_reset();
  endtask

  task automatic test_reset_in_wait();
    bit got;
    run_op(1'b1, 1'b0, 32'h8000_0000, 64'd0, 8'hFF, 7'h01, 0, 0, 64'hCAFE_F00D_1234_5678, 1'b0);
    @(negedge clk);
    inst_update = 1'b1;
    @(negedge clk);
    inst_update = 1'b0; data_ram_en = 1'b1; data_ram_wen = 1'b0;
    addr = 32'h8000_0010; l_choose = 7'h01; wmask = 8'hFF;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_req_valid) begin bus.mem_req_ready = 1'b1; got = 1'b1; break; end
    end
    checks++; if (!got) begin failures++; $display("FAIL rstwait_req got=0 exp=1"); end
    @(negedge clk);                      // DUT now in WAIT
    bus.mem_req_ready = 1'b0;
    checks++; if (mem_finish !== 1'b0) begin failures++; $display("FAIL rstwait_fin_wait got=%b exp=0", mem_finish); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_finish !== 1'b0) begin failures++; $display("FAIL rstwait_fin_idle got=%b exp=0", mem_finish); end
    rst = 1'b0; data_ram_en = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 64'h7777_6666_5555_4444;  // stale
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    checks++; if (load_data !== 64'd0) begin failures++; $display("FAIL rstwait_load got=%h exp=0", load_data); end
    checks++; if (bus.mem_req_valid !== 1'b0 || mem_err !== 1'b0) begin failures++; $display("FAIL rstwait_idle got=%b/%b exp=0/0", bus.mem_req_valid, mem_err); end
    model_ld = 64'd0;
    run_op(1'b1, 1'b0, 32'h8000_0018, 64'd0, 8'hFF, 7'h10, 0, 0, 64'h0000_0000_0000_9ABC, 1'b0);
    model_ld = 64'h9ABC;
    checks++; if (obs_fin_k != 4 || obs_load !== model_ld) begin failures++; $display("FAIL rstwait_after got=%0d/%h exp=4/%h", obs_fin_k, obs_load, model_ld); end
  endtask

  task automatic test_random();
    logic [7:0]  masks [4] = '{8'h01, 8'h03, 8'h0F, 8'hFF};
    for (int i = 0; i < 24; i++) begin
      bit          en, wen, e;
      int          r, n, rw, sw, exp_fin;
      logic [6:0]  lch;
      logic [7:0]  wm, exp_strb;
      logic [31:0] a;
      logic [63:0] wd, rd, exp_wd;
      r = $urandom_range(0, 9);
      en = (r <= 5); wen = (r == 0) || (r >= 6);
      lch = 7'(1 << $urandom_range(0, 6));
      wm = masks[$urandom_range(0, 3)];
      n = en ? load_bytes(lch) : store_bytes(wm);
      a = 32'h8000_0000 | ($urandom & 32'h0000_FFF8);
      if ($urandom_range(0, 2) == 0) a = a | 32'($urandom_range(0, 7));
      else a = a | 32'(n * $urandom_range(0, (8 / n) - 1));
      wd = {$urandom, $urandom}; rd = {$urandom, $urandom};
      rw = $urandom_range(0, 3); sw = $urandom_range(0, 3);
      run_op(en, wen, a, wd, wm, lch, rw, sw, rd, 1'b0);
      e = model_err(en, wen, a, lch, wm);
      exp_fin = e ? 2 : 4 + rw + sw;
      if (e) model_ld = 64'd0;
      else if (en) model_ld = model_load(rd, a, lch);
      exp_wd = wd << (8 * int'(a[2:0]));
      exp_strb = wm << a[2:0];
      checks++; if (obs_fin_k != exp_fin || obs_fin_cnt != 1) begin failures++; $display("FAIL rnd%0d_finish got=%0d@%0d exp=1@%0d", i, obs_fin_cnt, obs_fin_k, exp_fin); end
      checks++; if (obs_err_cnt != int'(e) || obs_req_cnt != int'(!e)) begin failures++; $display("FAIL rnd%0d_err_req got=%0d/%0d exp=%0d/%0d", i, obs_err_cnt, obs_req_cnt, e, !e); end
      checks++; if (obs_load !== model_ld) begin failures++; $display("FAIL rnd%0d_load a=%h lch=%h got=%h exp=%h", i, a, lch, obs_load, model_ld); end
      if (!e) begin
        checks++; if (obs_addr !== {a[31:3], 3'b000} || obs_wen !== wen || !obs_stable) begin failures++; $display("FAIL rnd%0d_req got=%h/%b/%b exp=%h/%b/1", i, obs_addr, obs_wen, obs_stable, {a[31:3], 3'b000}, wen); end
        if (wen) begin
          checks++; if (obs_wdata !== exp_wd || obs_wstrb !== exp_strb) begin failures++; $display("FAIL rnd%0d_store got=%h/%h exp=%h/%h", i, obs_wdata, obs_wstrb, exp_wd, exp_strb); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; inst_update = 1'b0; data_ram_en = 1'b0; data_ram_wen = 1'b0;
    wmask = '0; l_choose = '0; addr = '0; wdata = '0; model_ld = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    test_reset();
    test_non_mem();
    test_lb();
    test_sh();
    test_misaligned();
    test_served();
    test_update_at_done();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
